// File: rtl/dnn_acc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : dnn_acc_pkg                                                    |
// | Purpose : Shared types and constants for the accelerator read arbiter:   |
// |           FSM state encoding, AXI burst/response codes, beat-counter     |
// |           width.                                                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package dnn_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Wide enough to count a full 16-beat AXI3 burst (0..16).
  localparam int BEAT_CNT_W = 5;

endpackage
`default_nettype wire

// File: rtl/dnn_acc_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dnn_acc_rr_pick                                                |
// | Purpose : Two-way winner selection for the read arbiter.                 |
// |           DNN_ACC_RD_ARB_RR_EN defined : round-robin against last_grant. |
// |           DNN_ACC_RD_ARB_RR_EN undefined : fixed priority, req0 wins.    |
// | Ports   : req0, req1   - requester AR valid                              |
// |           last_grant   - index of the previous owner                     |
// |           pick         - winning index (meaningful when any req high)    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dnn_acc_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic pick
);

`ifdef DNN_ACC_RD_ARB_RR_EN
  // Contention goes to whoever did not own the port last time.
  assign pick = (req0 && req1) ? ~last_grant : req1;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign pick = req1 & ~req0;
`endif

endmodule
`default_nettype wire

// File: rtl/dnn_acc_rd_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dnn_acc_rd_arb                                                 |
// | Purpose : Arbitrates two AXI3 read requesters onto one shared read port, |
// |           one outstanding burst at a time (IDLE -> ADDR -> DATA).        |
// | Ports   : user_clk/user_reset - clock, sync active-high reset            |
// |           m0_*/m1_*  - requester AR and R channels                       |
// |           s_*        - shared-port AR and R channels (ID = grant)        |
// |           grant      - current owner index                               |
// |           len_err    - sticky: wrong beat count or wrong RID seen        |
// | Config  : DNN_ACC_RD_ARB_RR_EN selects round-robin (else fixed prio).    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dnn_acc_rd_arb
  import dnn_acc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic              user_clk,
  input  logic              user_reset,
  // requester 0
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // requester 1
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // shared port
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arid,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rid,
  input  logic              s_rvalid,
  output logic              s_rready,
  // status
  output logic              grant,
  output logic              len_err
);

  state_t                  state;
  logic                    last_grant;
  logic [LEN_W-1:0]        arlen_q;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic                    pick;
  logic                    in_addr;
  logic                    in_data;
  logic                    r_hs;

  dnn_acc_rr_pick u_pick (
    .req0       (m0_arvalid),
    .req1       (m1_arvalid),
    .last_grant (last_grant),
    .pick       (pick)
  );

  assign in_addr = (state == ST_ADDR);
  assign in_data = (state == ST_DATA);
  assign r_hs    = in_data & s_rvalid & s_rready;

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      arlen_q    <= '0;
      beat_cnt   <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            grant <= pick;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arready) begin
            arlen_q    <= grant ? m1_arlen : m0_arlen;
            last_grant <= grant;
            beat_cnt   <= '0;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            if (s_rid != grant) len_err <= 1'b1;
            if (s_rlast) begin
              // beat_cnt holds beats already taken, so this is beat
              // beat_cnt+1; it must equal arlen+1.
              if (beat_cnt != BEAT_CNT_W'(arlen_q)) len_err <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address channel: payload follows the owner; only the owner sees ready.
  assign s_arvalid  = in_addr;
  assign s_arid     = grant;
  assign s_araddr   = grant ? m1_araddr  : m0_araddr;
  assign s_arlen    = grant ? m1_arlen   : m0_arlen;
  assign s_arsize   = grant ? m1_arsize  : m0_arsize;
  assign s_arburst  = grant ? m1_arburst : m0_arburst;
  assign m0_arready = in_addr & ~grant & s_arready;
  assign m1_arready = in_addr &  grant & s_arready;

  // Read data: payload fans out to both, valid is qualified by ownership.
  assign m0_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rdata  = s_rdata;
  assign m1_rresp  = s_rresp;
  assign m1_rlast  = s_rlast;
  assign m0_rvalid = in_data & ~grant & s_rvalid;
  assign m1_rvalid = in_data &  grant & s_rvalid;
  assign s_rready  = in_data & (grant ? m1_rready : m0_rready);

endmodule
`default_nettype wire

// File: tb/tb_dnn_acc_rd_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dnn_acc_rd_arb                                              |
// | Purpose : Self-checking bench for dnn_acc_rd_arb. Beats driven from the  |
// |           slave side are queued as expectations and popped when the      |
// |           granted requester accepts them.                                |
// | Config  : DNN_ACC_RD_ARB_RR_EN selects round-robin expectations.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dnn_acc_rd_arb;
  import dnn_acc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] m0_araddr, m1_araddr;
  logic [3:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [63:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arid, s_arvalid, s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rid, s_rvalid, s_rready;
  logic        grant, len_err;

  dnn_acc_rd_arb dut (
    .user_clk(clk), .user_reset(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arid(s_arid), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .len_err(len_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [64:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic rvalid_of(input int m);
    return (m != 0) ? m1_rvalid : m0_rvalid;
  endfunction
  function automatic logic arready_of(input int m);
    return (m != 0) ? m1_arready : m0_arready;
  endfunction
  function automatic logic [63:0] rdata_of(input int m);
    return (m != 0) ? m1_rdata : m0_rdata;
  endfunction
  function automatic logic rlast_of(input int m);
    return (m != 0) ? m1_rlast : m0_rlast;
  endfunction
  function automatic logic [1:0] rresp_of(input int m);
    return (m != 0) ? m1_rresp : m0_rresp;
  endfunction

  // Raise AR on the masters in mask (m1 address = base+0x100), expect w to
  // win, hold s_arready low for 'stall' ADDR cycles, then handshake.
  task automatic do_addr(input int mask, input int w, input logic [31:0] base,
                         input logic [3:0] len, input int stall);
    logic [31:0] exp_addr;
    exp_addr   = base + ((w != 0) ? 32'h100 : 32'h0);
    m0_araddr  = base;          m1_araddr  = base + 32'h100;
    m0_arlen   = len;           m1_arlen   = len;
    m0_arsize  = 3'd3;          m1_arsize  = 3'd3;
    m0_arburst = AXI_BURST_INCR; m1_arburst = AXI_BURST_INCR;
    m0_arvalid = mask[0];
    m1_arvalid = mask[1];
    s_arready  = 1'b0;
    tick();
    for (int k = 0; k < stall; k++) begin
      chk("stall_arvalid", s_arvalid, 1);
      chk("stall_araddr", s_araddr, exp_addr);
      chk("stall_m0_arready", m0_arready, 0);
      chk("stall_m1_arready", m1_arready, 0);
      tick();
    end
    s_arready = 1'b1;
    #1;
    chk("grant", grant, w);
    chk("s_arvalid", s_arvalid, 1);
    chk("s_arid", s_arid, w);
    chk("s_araddr", s_araddr, exp_addr);
    chk("s_arlen", s_arlen, len);
    chk("s_arburst", s_arburst, AXI_BURST_INCR);
    chk("arready_owner", arready_of(w), 1);
    chk("arready_other", arready_of(1 - w), 0);
    tick();
    if (w != 0) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    s_arready = 1'b0;
  endtask

  // Slave drives nbeats beats (rlast on beat index last_at) with the given RID.
  task automatic do_data(input int m, input int nbeats, input int last_at,
                         input logic rid, input bit toggle);
    logic [63:0] d;
    logic [64:0] e;
    logic        phase;
    logic        rdy;
    logic        lst;
    bit          acc;
    int          guard;
    phase = 1'b0;
    guard = 0;
    for (int b = 0; b < nbeats; b++) begin
      d        = {$urandom, $urandom};
      lst      = (b == last_at);
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rresp  = AXI_RESP_OKAY;
      s_rlast  = lst;
      s_rid    = rid;
      sb.push_back({d, lst});
      acc = 1'b0;
      while (!acc && guard < 200) begin
        rdy   = toggle ? phase : 1'b1;
        phase = ~phase;
        if (m != 0) m1_rready = rdy; else m0_rready = rdy;
        #1;
        chk("s_rready_mirror", s_rready, rdy);
        chk("rvalid_owner", rvalid_of(m), 1);
        chk("rvalid_other", rvalid_of(1 - m), 0);
        chk("arready_other_data", arready_of(1 - m), 0);
        if (rdy) begin
          e = sb.pop_front();
          chk("rdata", rdata_of(m), e[64:1]);
          chk("rlast", rlast_of(m), e[0]);
          chk("rresp", rresp_of(m), AXI_RESP_OKAY);
          acc = 1'b1;
        end
        tick();
        guard++;
      end
      if (!acc) chk("beat_timeout", 0, 1);
    end
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
  endtask

  int w2;

  initial begin
    rst = 1'b1;
    m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0;
    m0_arsize = '0; m1_arsize = '0; m0_arburst = '0; m1_arburst = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    s_rid = 1'b0; s_rvalid = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    rst = 1'b0;

    // Contention straight out of reset: m0 first, then policy-dependent.
    do_addr(3, 0, 32'h4000, 4'd1, 0);
    do_data(0, 2, 1, 1'b0, 1'b0);
`ifdef DNN_ACC_RD_ARB_RR_EN
    w2 = 1;
`else
    w2 = 0;
`endif
    do_addr(3, w2, 32'h4000, 4'd1, 0);
    do_data(w2, 2, 1, w2[0], 1'b0);
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;

    // Plain 4-beat burst for m0.
    do_addr(1, 0, 32'h1000, 4'd3, 0);
    do_data(0, 4, 3, 1'b0, 1'b0);
    chk("idle_s_rready", s_rready, 0);
    chk("idle_s_arvalid", s_arvalid, 0);
    chk("len_err_ok1", len_err, 0);

    // Shared port stalls AR for 5 cycles.
    do_addr(2, 1, 32'h2000, 4'd2, 5);
    do_data(1, 3, 2, 1'b1, 1'b0);
    chk("len_err_ok2", len_err, 0);

    // 16-beat burst with requester ready toggling.
    do_addr(1, 0, 32'h3000, 4'd15, 0);
    do_data(0, 16, 15, 1'b0, 1'b1);
    chk("len_err_ok3", len_err, 0);

    // rlast one beat early.
    do_addr(2, 1, 32'h5000, 4'd1, 0);
    do_data(1, 1, 0, 1'b1, 1'b0);
    chk("len_err_early", len_err, 1);
    chk("early_idle_s_rready", s_rready, 0);
    do_addr(1, 0, 32'h6000, 4'd0, 0);
    do_data(0, 1, 0, 1'b0, 1'b0);
    chk("len_err_sticky", len_err, 1);

    // Reset on beat 2 of an 8-beat burst.
    do_addr(2, 1, 32'h7000, 4'd7, 0);
    do_data(1, 2, -1, 1'b1, 1'b0);
    s_rvalid = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_s_rready", s_rready, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_len_err", len_err, 0);
    chk("midrst_m1_rvalid", m1_rvalid, 0);
    rst = 1'b0;
    s_rvalid = 1'b0;
    tick();

    // Wrong RID on a single-beat burst.
    do_addr(1, 0, 32'h8000, 4'd0, 0);
    do_data(0, 1, 0, 1'b1, 1'b0);
    chk("len_err_rid", len_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dnn_acc_rd_arb.md
DNN_ACC_RD_ARB -- requirements
Module: dnn_acc_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI read address width.
REQ-002 SHALL have parameter DATA_W, default 64, AXI read data width.
REQ-003 SHALL have parameter LEN_W, default 4, AXI3 burst length field width.
REQ-004 SHALL have port user_clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port user_reset, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have ports mI_araddr/arlen/arsize/arburst (I=0,1), input, ADDR_W/LEN_W/3/2, requester I read-address payload.
REQ-007 SHALL have ports mI_arvalid, input, 1, and mI_arready, output, 1, requester I AR handshake.
REQ-008 SHALL have ports mI_rdata/rresp/rlast, output, DATA_W/2/1, requester I read-data payload.
REQ-009 SHALL have ports mI_rvalid, output, 1, and mI_rready, input, 1, requester I R handshake.
REQ-010 SHALL have ports s_araddr/arlen/arsize/arburst, output, ADDR_W/LEN_W/3/2, shared-port address payload.
REQ-011 SHALL have ports s_arid, output, 1, s_arvalid, output, 1, and s_arready, input, 1.
REQ-012 SHALL have ports s_rdata/rresp/rlast/rid, input, DATA_W/2/1/1, and s_rvalid, input, 1, and s_rready, output, 1.
REQ-013 SHALL have ports grant, output, 1, owning requester index, and len_err, output, 1, sticky beat-count error.

Function
REQ-014 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, single outstanding burst.
REQ-015 IDLE: any mI_arvalid high -> winner latched into grant, go ADDR next cycle; arbitration latency 1 cycle.
REQ-016 ADDR: s_arvalid=1, s_ar* = granted payload, s_arid=grant, mI_arready=s_arready for grant only; on s_arvalid&s_arready latch arlen, go DATA.
REQ-017 DATA: s_rdata/rresp/rlast -> mI_r* of grant, mI_rvalid=s_rvalid, s_rready=mI_rready of grant; non-granted mI_rvalid=0.
REQ-018 DATA: 5-bit beat counter increments per s_rvalid&s_rready; on beat with s_rlast go IDLE.
REQ-019 len_err SHALL set if s_rlast arrives at beat != arlen+1, or s_rid != grant on any beat; clears only on reset.
REQ-020 non-granted mI_arready SHALL be 0 in every state; s_arvalid=0 outside ADDR; s_rready=0 outside DATA.
REQ-021 back-to-back: requester holding arvalid after its last beat SHALL re-arbitrate in IDLE (one idle bubble cycle minimum).
REQ-022 requesters SHALL hold AR payload stable until arready (AXI rule); block does not buffer payload.

Reset
REQ-023 reset SHALL force IDLE, grant=0, last-grant=1, beat counter=0, len_err=0; all valid/ready outputs 0 the following cycle.
REQ-024 reset mid-burst SHALL abandon the burst; remaining slave beats are not tracked (slave reset together).

Configuration
REQ-025 macro DNN_ACC_RD_ARB_RR_EN defined: round-robin; when both request, winner = index != last grant; last grant updated on each ADDR handshake.
REQ-026 macro undefined: fixed priority, m0 wins whenever m0_arvalid is high.

Structure
REQ-027 dnn_acc_pkg SHALL hold FSM state encoding, AXI burst/resp constants, beat-counter width.
REQ-028 winner selection SHALL be sub-module dnn_acc_rr_pick (2-way, RR/fixed per macro); rest in top.

Verification
REQ-029 m0 only, araddr=0x1000, arlen=3 -> s_arid=0, 4 beats routed to m0, m1_rvalid=0 throughout, len_err=0.
REQ-030 m0,m1 arvalid same cycle, RR_EN -> m0 served first (reset last-grant=1), then m1; without RR_EN and m0 persistently requesting -> m1 never granted.
REQ-031 s_arready held low 5 cycles in ADDR -> s_arvalid stays 1, payload stable, m0/m1 arready 0 until handshake.
REQ-032 arlen=1 but s_rlast on beat 1 -> len_err=1 and stays 1; FSM returns IDLE.
REQ-033 user_reset asserted in DATA on beat 2 -> next cycle IDLE, s_rready=0, grant=0, len_err=0.
REQ-034 mI_rready toggled every cycle during a 16-beat burst -> s_rready mirrors it, all 16 beats delivered in order.
